// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default baud divisor,
// frame-length helper and the parity function used by uart_tx and uart_rx.
`timescale 1ns/1ps
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   // 25 MHz clock / 9600 baud
   localparam int unsigned BAUD_DIV_DEFAULT = 32'd2604;
   // start + 8 data + 1 stop
   localparam int unsigned FRAME_BITS_MIN   = 32'd10;

   function automatic int unsigned frame_cycles(input int unsigned baud_div,
                                                input int unsigned parity_en,
                                                input int unsigned stop_bits);
      return (FRAME_BITS_MIN + parity_en + stop_bits - 32'd1) * baud_div;
   endfunction

   // Even parity: the bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BAUD_DIV-1 and flags the last cycle of each bit.
// restart clears the count so a new state always gets a full bit period.
`timescale 1ns/1ps
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input  logic clk,
   input  logic clr,
   input  logic restart,
   output logic bit_done
);

   localparam logic [15:0] LAST_C = 16'(BAUD_DIV - 32'd1);

   logic [15:0] cnt_r;

   // Bit-period counter with synchronous clear and restart
   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_r <= 16'd0;
      end else if (restart) begin
         cnt_r <= 16'd0;
      end else if (cnt_r == LAST_C) begin
         cnt_r <= 16'd0;
      end else begin
         cnt_r <= cnt_r + 16'd1;
      end
   end

   assign bit_done = (cnt_r == LAST_C);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: holding register plus shift register so the next byte can
// be queued while the current frame shifts out; TxD is driven from a flop.
`timescale 1ns/1ps
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV  = BAUD_DIV_DEFAULT,
   parameter int unsigned PARITY_EN = 32'd0,
   parameter int unsigned STOP_BITS = 32'd1
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       ready,
   input  logic [7:0] tx_data,
   output logic       tdre,
   output logic       tx_busy,
   output logic       TxD
);

   localparam logic [2:0] STOP_LAST_C = 3'(STOP_BITS - 32'd1);

   tx_state_e  state_r;
   tx_state_e  state_next_s;
   logic [2:0] bit_cnt_r;
   logic [2:0] bit_cnt_next_s;
   logic [7:0] hold_r;
   logic [7:0] shift_r;
   logic       parity_r;
   logic       tdre_r;
   logic       tx_busy_r;
   logic       txd_r;
   logic       take_s;
   logic       shift_en_s;
   logic       txd_s;
   logic       bit_done_s;
   logic       restart_s;

   // Every state entry starts a fresh bit period
   assign restart_s = (state_next_s != state_r);

   uart_baud_gen #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud (
      .clk      (clk),
      .clr      (clr),
      .restart  (restart_s),
      .bit_done (bit_done_s)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (clr) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state, line level and datapath controls
   always_comb begin
      state_next_s   = state_r;
      bit_cnt_next_s = bit_cnt_r;
      take_s         = 1'b0;
      shift_en_s     = 1'b0;
      txd_s          = 1'b1;
      case (state_r)
         ST_IDLE: begin
            txd_s = 1'b1;
            if (!tdre_r) begin
               take_s       = 1'b1;
               state_next_s = ST_START;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_START: begin
            txd_s = 1'b0;
            if (bit_done_s) begin
               state_next_s = ST_DATA;
            end else begin
               state_next_s = ST_START;
            end
         end
         ST_DATA: begin
            txd_s = shift_r[0];
            if (bit_done_s) begin
               shift_en_s = 1'b1;
               if (bit_cnt_r == 3'd7) begin
                  bit_cnt_next_s = 3'd0;
                  if (PARITY_EN != 32'd0) begin
                     state_next_s = ST_PARITY;
                  end else begin
                     state_next_s = ST_STOP;
                  end
               end else begin
                  bit_cnt_next_s = bit_cnt_r + 3'd1;
               end
            end else begin
               state_next_s = ST_DATA;
            end
         end
         ST_PARITY: begin
            txd_s = parity_r;
            if (bit_done_s) begin
               state_next_s = ST_STOP;
            end else begin
               state_next_s = ST_PARITY;
            end
         end
         ST_STOP: begin
            txd_s = 1'b1;
            // bit_cnt_r doubles as the stop-bit counter
            if (bit_done_s) begin
               if (bit_cnt_r == STOP_LAST_C) begin
                  bit_cnt_next_s = 3'd0;
                  if (!tdre_r) begin
                     take_s       = 1'b1;
                     state_next_s = ST_START;
                  end else begin
                     state_next_s = ST_IDLE;
                  end
               end else begin
                  bit_cnt_next_s = bit_cnt_r + 3'd1;
               end
            end else begin
               state_next_s = ST_STOP;
            end
         end
         default: begin
            state_next_s   = ST_IDLE;
            bit_cnt_next_s = 3'd0;
            txd_s          = 1'b1;
         end
      endcase
   end

   // Holding register, shift register, parity and bit counter
   always_ff @(posedge clk) begin
      if (clr) begin
         hold_r    <= 8'h00;
         shift_r   <= 8'h00;
         parity_r  <= 1'b0;
         tdre_r    <= 1'b1;
         bit_cnt_r <= 3'd0;
      end else begin
         bit_cnt_r <= bit_cnt_next_s;
         if (take_s) begin
            shift_r  <= hold_r;
            parity_r <= even_parity(hold_r);
            tdre_r   <= 1'b1;
         end else if (shift_en_s) begin
            shift_r <= {1'b0, shift_r[7:1]};
         end else begin
            shift_r <= shift_r;
         end
         // Load and transfer are exclusive: load needs an empty holding register
         if (tdre_r && ready) begin
            hold_r <= tx_data;
            tdre_r <= 1'b0;
         end else begin
            hold_r <= hold_r;
         end
      end
   end

   // Registered line and busy outputs
   always_ff @(posedge clk) begin
      if (clr) begin
         txd_r     <= 1'b1;
         tx_busy_r <= 1'b0;
      end else begin
         txd_r     <= txd_s;
         tx_busy_r <= (state_next_s != ST_IDLE);
      end
   end

   assign tdre    = tdre_r;
   assign tx_busy = tx_busy_r;
   assign TxD     = txd_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: one instance without parity / one stop bit,
// one with even parity and two stop bits; frames decoded from TxD by a monitor.
`timescale 1ns/1ps
module tb_uart_tx;

   localparam int BD   = 4;
   localparam int FL_A = 10 * BD;
   localparam int FL_B = 12 * BD;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_clr, a_ready, a_tdre, a_busy, a_txd;
   logic       b_clr, b_ready, b_tdre, b_busy, b_txd;
   logic [7:0] a_data, b_data;

   uart_tx #(.BAUD_DIV(BD), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
      .clk(clk), .clr(a_clr), .ready(a_ready), .tx_data(a_data),
      .tdre(a_tdre), .tx_busy(a_busy), .TxD(a_txd));

   uart_tx #(.BAUD_DIV(BD), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
      .clk(clk), .clr(b_clr), .ready(b_ready), .tx_data(b_data),
      .tdre(b_tdre), .tx_busy(b_busy), .TxD(b_txd));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0]  a_exp_q[$], b_exp_q[$];
   logic [63:0] a_frm_q[$], b_frm_q[$];
   int          a_t0_q[$],  b_t0_q[$];

   // Frame capture: a falling line starts a frame of a fixed number of samples
   logic [63:0] a_buf, b_buf;
   int a_pos = -1, b_pos = -1, a_t0, b_t0;
   always @(negedge clk) begin
      if (a_clr) a_pos <= -1;
      else if (a_pos < 0) begin
         if (!a_txd) begin a_buf <= '0; a_pos <= 1; a_t0 <= cyc; end
      end else if (a_pos == FL_A - 1) begin
         a_frm_q.push_back(a_buf | (64'(a_txd) << a_pos));
         a_t0_q.push_back(a_t0);
         a_pos <= -1;
      end else begin
         a_buf[a_pos] <= a_txd; a_pos <= a_pos + 1;
      end
   end
   always @(negedge clk) begin
      if (b_clr) b_pos <= -1;
      else if (b_pos < 0) begin
         if (!b_txd) begin b_buf <= '0; b_pos <= 1; b_t0 <= cyc; end
      end else if (b_pos == FL_B - 1) begin
         b_frm_q.push_back(b_buf | (64'(b_txd) << b_pos));
         b_t0_q.push_back(b_t0);
         b_pos <= -1;
      end else begin
         b_buf[b_pos] <= b_txd; b_pos <= b_pos + 1;
      end
   end

   // Reference: line level for every cycle of the frame carrying byte d
   function automatic logic [63:0] frame_wave(input logic [7:0] d, input int par, input int stops);
      logic [63:0] w;
      int nb, k;
      w  = '0;
      nb = 10 + par + stops - 1;
      for (int i = 0; i < nb * BD; i++) begin
         k = i / BD;
         if (k == 0) w[i] = 1'b0;
         else if (k <= 8) w[i] = d[k-1];
         else if (k == 9 && par != 0) w[i] = ^d;
         else w[i] = 1'b1;
      end
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic load(input bit sel, input logic [7:0] d, input bit expect_frame);
      int k = 0;
      while (((sel ? b_tdre : a_tdre) !== 1'b1) && k < 500) begin tick(); k++; end
      chk("load_wait", 64'(k < 500), 64'd1);
      if (sel) begin b_ready = 1'b1; b_data = d; if (expect_frame) b_exp_q.push_back(d); end
      else     begin a_ready = 1'b1; a_data = d; if (expect_frame) a_exp_q.push_back(d); end
      tick();
      if (sel) b_ready = 1'b0; else a_ready = 1'b0;
   endtask

   task automatic wait_idle(input bit sel);
      int k = 0;
      while (!((sel ? b_tdre : a_tdre) && !(sel ? b_busy : a_busy)) && k < 3000) begin
         tick(); k++;
      end
      chk("idle_wait", 64'(k < 3000), 64'd1);
      repeat (3) tick();
   endtask

   task automatic check_frames(input bit sel);
      logic [63:0] got;
      logic [7:0]  e;
      int na, ne, t;
      na = sel ? b_frm_q.size() : a_frm_q.size();
      ne = sel ? b_exp_q.size() : a_exp_q.size();
      chk(sel ? "b_frame_count" : "a_frame_count", 64'(na), 64'(ne));
      while (na > 0 && ne > 0) begin
         if (sel) begin got = b_frm_q.pop_front(); t = b_t0_q.pop_front(); e = b_exp_q.pop_front(); end
         else     begin got = a_frm_q.pop_front(); t = a_t0_q.pop_front(); e = a_exp_q.pop_front(); end
         chk(sel ? "b_frame" : "a_frame", got, frame_wave(e, sel ? 1 : 0, sel ? 2 : 1));
         na--; ne--;
      end
      a_frm_q.delete(); a_t0_q.delete(); a_exp_q.delete();
      b_frm_q.delete(); b_t0_q.delete(); b_exp_q.delete();
   endtask

   typedef struct {
      logic       ready;
      logic [7:0] data;
      logic       tdre;
      logic       busy;
      logic       txd;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int busy_cnt, t_load, gap;
      logic [7:0] d;

      // Load at edge n, ignored ready in the transfer cycle, start bit from n+2
      tbl[0] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1};
      tbl[1] = '{1'b1, 8'hEE, 1'b1, 1'b1, 1'b1};
      tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
      tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1};

      a_clr = 1'b1; b_clr = 1'b1; a_ready = 1'b0; b_ready = 1'b0;
      a_data = 8'h00; b_data = 8'h00;
      repeat (3) tick();
      a_clr = 1'b0; b_clr = 1'b0;
      chk("rst_a_tdre", 64'(a_tdre), 64'd1);
      chk("rst_a_busy", 64'(a_busy), 64'd0);
      chk("rst_a_txd",  64'(a_txd),  64'd1);
      chk("rst_b_tdre", 64'(b_tdre), 64'd1);
      chk("rst_b_busy", 64'(b_busy), 64'd0);
      chk("rst_b_txd",  64'(b_txd),  64'd1);
      tick();

      // Single byte 0x55
      busy_cnt = 0; t_load = 0;
      for (int i = 0; i < 8; i++) begin
         a_ready = tbl[i].ready; a_data = tbl[i].data;
         if (i == 0) a_exp_q.push_back(tbl[i].data);
         tick();
         if (i == 0) t_load = cyc;
         busy_cnt += int'(a_busy);
         chk($sformatf("vec%0d_tdre", i), 64'(a_tdre), 64'(tbl[i].tdre));
         chk($sformatf("vec%0d_busy", i), 64'(a_busy), 64'(tbl[i].busy));
         chk($sformatf("vec%0d_txd", i),  64'(a_txd),  64'(tbl[i].txd));
      end
      a_ready = 1'b0;
      repeat (50) begin tick(); busy_cnt += int'(a_busy); end
      chk("a_busy_len", 64'(busy_cnt), 64'd40);
      chk("a_start_lat", 64'(a_t0_q.size() > 0 ? a_t0_q[0] - t_load : -1), 64'd2);
      check_frames(1'b0);

      // Back-to-back frames with no idle gap
      load(1'b0, 8'hA3, 1'b1);
      load(1'b0, 8'h0F, 1'b1);
      wait_idle(1'b0);
      chk("b2b_gap", 64'(a_t0_q.size() == 2 ? a_t0_q[1] - a_t0_q[0] : -1), 64'(FL_A));
      check_frames(1'b0);

      // Ready while the holding register is full is ignored
      load(1'b0, 8'h12, 1'b1);
      a_ready = 1'b1; a_data = 8'hFF; tick(); a_ready = 1'b0;
      load(1'b0, 8'h34, 1'b1);
      a_ready = 1'b1; a_data = 8'hFF;
      repeat (10) tick();
      a_ready = 1'b0;
      wait_idle(1'b0);
      check_frames(1'b0);

      // Parity and two stop bits on 0x07
      load(1'b1, 8'h07, 1'b1);
      busy_cnt = 0;
      repeat (60) begin tick(); busy_cnt += int'(b_busy); end
      chk("b_busy_len", 64'(busy_cnt), 64'd48);
      wait_idle(1'b1);
      check_frames(1'b1);

      // Reset during data bit 3 with a byte pending in the holding register
      load(1'b0, 8'hC6, 1'b0);
      load(1'b0, 8'h99, 1'b0);
      repeat (16) tick();
      chk("pre_clr_txd", 64'(a_txd), 64'd0);
      a_clr = 1'b1; tick(); a_clr = 1'b0;
      chk("clr_txd",  64'(a_txd),  64'd1);
      chk("clr_tdre", 64'(a_tdre), 64'd1);
      chk("clr_busy", 64'(a_busy), 64'd0);
      repeat (60) tick();
      check_frames(1'b0);
      load(1'b0, 8'h81, 1'b1);
      wait_idle(1'b0);
      check_frames(1'b0);

      // Random traffic on both instances, with ignored loads mixed in
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 16; i++) begin
            d   = 8'($urandom);
            gap = int'($urandom_range(0, 6));
            repeat (gap) tick();
            if ($urandom_range(0, 1) == 1 && (s == 1 ? b_tdre : a_tdre) == 1'b0) begin
               if (s == 1) begin b_ready = 1'b1; b_data = 8'($urandom); tick(); b_ready = 1'b0; end
               else        begin a_ready = 1'b1; a_data = 8'($urandom); tick(); a_ready = 1'b0; end
            end
            load(s == 1, d, 1'b1);
         end
         wait_idle(s == 1);
         check_frames(s == 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter; the transmit counterpart of uart_rx, running on the same clk25 domain.
Accepts a byte through a one-register handshake (tdre / ready) and serialises it on TxD.
Frame format: 1 start bit, 8 data bits LSB first, optional even parity bit, 1 or 2 stop bits.
Double-buffered (holding register plus shift register) so a controller can queue the next byte while the current one is shifting out.

Parameters:
BAUD_DIV, 2604, clk cycles per bit (25 MHz / 9600 baud); legal range 2..65535.
PARITY_EN, 0, 1 inserts an even-parity bit after bit 7.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock (clk25 in the top level); single clock domain.
clr  input  1  reset; synchronous, active-high.
ready  input  1  load strobe; sampled only while tdre=1.
tx_data  input  8  byte to transmit; sampled on the edge where ready is accepted.
tdre  output  1  transmit data register empty; 1 = holding register can accept a byte.
tx_busy  output  1  1 whenever a frame is on the line (FSM not in IDLE).
TxD  output  1  serial line; registered, idles high.

Behaviour:
- Clock and reset: one clock, clk; clr is synchronous, active-high, and takes priority over every other input.
- Reset values: TxD=1, tdre=1, tx_busy=0, state=IDLE, bit counter=0, baud counter=0, holding register=0x00, shift register=0x00.
- Reset mid-frame: on the next edge TxD returns to 1 and the frame is aborted. The pending holding byte is discarded.
- Load handshake:
  - ready=1 and tdre=1 at edge n: tx_data is copied into the holding register and tdre=0 after edge n.
  - ready while tdre=0 is ignored. The holding register is not overwritten and no error is flagged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TxD=1. If the holding register is full, move it to the shift register, set tdre=1, compute parity, go to START.
  - START: TxD=0 for BAUD_DIV cycles.
  - DATA: TxD=shift[0] for BAUD_DIV cycles per bit, shifting right between bits. After 8 bits (bit counter 7 to 0 wrap), go to PARITY if PARITY_EN, else STOP.
  - PARITY: TxD = XOR of the 8 data bits, for BAUD_DIV cycles.
  - STOP: TxD=1 for STOP_BITS*BAUD_DIV cycles.
    - Then, if the holding register is full, transfer it as in IDLE and go directly to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- Latency:
  - ready accepted at edge n: the transfer happens at edge n+1, and TxD falls at edge n+2.
  - Each bit lasts exactly BAUD_DIV cycles.
  - Frame length = (10 + PARITY_EN + STOP_BITS - 1) * BAUD_DIV cycles.
- Baud counter: counts 0..BAUD_DIV-1, clears on every state entry, and produces a one-cycle bit_done when it reaches BAUD_DIV-1.
- tdre timing: tdre rises on the same edge as the holding-to-shift transfer. ready in that same cycle sees tdre=0 and is ignored; the next byte can load one cycle later.
- tx_busy=1 in START, DATA, PARITY and STOP.
- TxD must never glitch: it is driven only from a flop.

Decomposition:
- Package uart_pkg:
  - FSM state encoding.
  - Default BAUD_DIV constant, shared with uart_rx.
  - Frame-length helper constant.
- Sub-module uart_baud_gen: a counter with bit_done output and a restart input. It is natural to share it with uart_rx.
- The rest (FSM, holding register, shift register, parity) stays in uart_tx.

Test Plan:
- Single byte: BAUD_DIV=4, ready pulse with tx_data=0x55.
  -> TxD falls 2 cycles later and emits 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles.
  -> tdre back to 1 one cycle after ready; tx_busy is 1 for 40 cycles.
- Back-to-back: load 0xA3, then load 0x0F as soon as tdre=1.
  -> Second start bit begins on the cycle right after the first stop bit ends; 0x0F frame is correct.
- Ignored load: load 0x12, then ready with 0xFF while tdre=0.
  -> Only 0x12 then idle; 0xFF never appears on TxD.
- Parity/stop: PARITY_EN=1, STOP_BITS=2, send 0x07.
  -> Parity bit=1, followed by 8 cycles of TxD=1; total frame 48 cycles.
- Reset mid-frame: clr asserted during DATA bit 3.
  -> Next edge gives TxD=1, tdre=1, tx_busy=0.
  -> A later load of 0x81 transmits cleanly.
- Loopback: uart_tx TxD wired to uart_rx RxD with matching BAUD_DIV, bytes 0x00, 0xFF, 0x5A.
  -> rdrf pulses with identical rx_data and FE=0.
